// File: rtl/telem_link_pkg.sv
// Shared telemetry link definitions: control characters, idle word and framer states.
package telem_link_pkg;

    localparam logic [7:0]  K_COMMA   = 8'hBC;  // K28.5
    localparam logic [7:0]  K_SOF     = 8'hFB;  // K27.7
    localparam logic [7:0]  K_EOF     = 8'hFD;  // K29.7
    localparam logic [31:0] IDLE_WORD = {8'h50, 8'h50, 8'h50, K_COMMA};
    // Control words carry their K character in byte0 only.
    localparam logic [3:0]  K_CTRL    = 4'b0001;

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StIdle    = 2'd1,
        StPayload = 2'd2,
        StEof     = 2'd3
    } link_state_e;

endpackage

// File: rtl/telem_rx_deframer_if.sv
// Decoded GT RX word bus: the GT wrapper drives it, the deframer consumes it.
interface telem_rx_deframer_if;
    logic        gt0_rx_fsm_reset_done_in;
    logic [31:0] gt0_rxdata_in;
    logic [3:0]  gt0_rxcharisk_in;
    logic [3:0]  gt0_rxdisperr_in;
    logic [3:0]  gt0_rxnotintable_in;
    logic        gt0_rxbyteisaligned_in;

    modport master (
        output gt0_rx_fsm_reset_done_in, gt0_rxdata_in, gt0_rxcharisk_in,
               gt0_rxdisperr_in, gt0_rxnotintable_in, gt0_rxbyteisaligned_in
    );

    modport slave (
        input gt0_rx_fsm_reset_done_in, gt0_rxdata_in, gt0_rxcharisk_in,
              gt0_rxdisperr_in, gt0_rxnotintable_in, gt0_rxbyteisaligned_in
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Increment on request unless already saturated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/telem_rx_deframer.sv
// Telemetry RX deframer: lock on idles, strip SOF/EOF, check checksum and sequence.
module telem_rx_deframer
    import telem_link_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 4,
    parameter int unsigned LOCK_IDLES    = 16
) (
    input  logic                gt0_rxusrclk2_in,
    input  logic                soft_reset_rx_in,
    telem_rx_deframer_if.slave  gt_rx,
    output logic                locked_out,
    output logic [31:0]         payload_data_out,
    output logic                payload_valid_out,
    output logic                payload_sof_out,
    output logic                payload_eof_out,
    output logic [23:0]         seq_out,
    output logic                frame_ok_out,
    output logic                frame_err_out,
    output logic                seq_gap_out,
    output logic [15:0]         frame_ok_count_out,
    output logic [15:0]         frame_err_count_out,
    output logic [15:0]         code_err_count_out
);

    localparam logic [7:0] LockLast = 8'(LOCK_IDLES - 1);
    localparam logic [7:0] WordLast = 8'(PAYLOAD_WORDS - 1);

    // Input stage (word seen at edge N, outputs at edge N+1).
    logic [31:0] in_data_q;
    logic [3:0]  in_k_q;
    logic        in_ce_q, in_done_q;

    link_state_e state_q, state_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d, word_cnt_q, word_cnt_d, csum_q, csum_d;
    logic [23:0] seq_q, seq_d;
    logic        first_sof_q, first_sof_d;
    logic        locked_q, valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
    logic        ok_q, ok_d, err_q, err_d, gap_q, gap_d, ce_inc;
    logic [31:0] data_q, data_d;
    logic        is_idle, is_sof, is_eof_good, is_data;

    // Register the raw word and fold the per-byte error flags into one code-error bit.
    always_ff @(posedge gt0_rxusrclk2_in or posedge soft_reset_rx_in) begin
        if (soft_reset_rx_in) begin
            in_data_q <= '0;
            in_k_q    <= '0;
            in_ce_q   <= 1'b0;
            in_done_q <= 1'b0;
        end else begin
            in_data_q <= gt_rx.gt0_rxdata_in;
            in_k_q    <= gt_rx.gt0_rxcharisk_in;
            in_ce_q   <= (|gt_rx.gt0_rxdisperr_in) | (|gt_rx.gt0_rxnotintable_in) |
                         ~gt_rx.gt0_rxbyteisaligned_in;
            in_done_q <= gt_rx.gt0_rx_fsm_reset_done_in;
        end
    end

    assign is_idle     = (in_data_q == IDLE_WORD) && (in_k_q == K_CTRL);
    assign is_sof      = (in_data_q[7:0] == K_SOF) && (in_k_q == K_CTRL);
    assign is_eof_good = (in_data_q[7:0] == K_EOF) && (in_k_q == K_CTRL) &&
                         (in_data_q[31:16] == 16'h0) && (in_data_q[15:8] == csum_q);
    assign is_data     = (in_k_q == 4'b0000);

    // Next-state and next-output decode for the link FSM.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        word_cnt_d  = word_cnt_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        first_sof_d = first_sof_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        gap_d       = 1'b0;
        ce_inc      = 1'b0;
        if (!in_done_q) begin
            state_d    = StHunt;
            idle_cnt_d = '0;
        end else if (in_ce_q && (state_q != StHunt)) begin
            ce_inc     = 1'b1;
            state_d    = StHunt;
            idle_cnt_d = '0;
            err_d      = (state_q == StPayload) || (state_q == StEof);
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (!in_ce_q && is_idle) begin
                        if (idle_cnt_q == LockLast) begin
                            state_d     = StIdle;
                            idle_cnt_d  = '0;
                            first_sof_d = 1'b1;  // no gap check against a pre-lock seq
                        end else begin
                            idle_cnt_d = idle_cnt_q + 8'd1;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                StIdle: begin
                    if (is_sof) begin
                        state_d     = StPayload;
                        seq_d       = in_data_q[31:8];
                        word_cnt_d  = '0;
                        csum_d      = '0;
                        gap_d       = !first_sof_q && (in_data_q[31:8] != seq_q + 24'd1);
                        first_sof_d = 1'b0;
                    end
                end
                StPayload: begin
                    if (is_data) begin
                        valid_d = 1'b1;
                        data_d  = in_data_q;
                        sof_d   = (word_cnt_q == 8'd0);
                        eof_d   = (word_cnt_q == WordLast);
                        csum_d  = csum_q + in_data_q[7:0] + in_data_q[15:8] +
                                  in_data_q[23:16] + in_data_q[31:24];
                        if (word_cnt_q == WordLast) begin
                            state_d = StEof;
                        end else begin
                            word_cnt_d = word_cnt_q + 8'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StEof: begin
                    ok_d    = is_eof_good;
                    err_d   = !is_eof_good;
                    state_d = StIdle;
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // Link FSM state and registered outputs.
    always_ff @(posedge gt0_rxusrclk2_in or posedge soft_reset_rx_in) begin
        if (soft_reset_rx_in) begin
            state_q     <= StHunt;
            idle_cnt_q  <= '0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
            seq_q       <= '0;
            first_sof_q <= 1'b0;
            locked_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            gap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            word_cnt_q  <= word_cnt_d;
            csum_q      <= csum_d;
            seq_q       <= seq_d;
            first_sof_q <= first_sof_d;
            locked_q    <= (state_d != StHunt);
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_ok_cnt (
        .clk_i   (gt0_rxusrclk2_in),
        .rst_i   (soft_reset_rx_in),
        .inc_i   (ok_d),
        .count_o (frame_ok_count_out)
    );

    sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk_i   (gt0_rxusrclk2_in),
        .rst_i   (soft_reset_rx_in),
        .inc_i   (err_d),
        .count_o (frame_err_count_out)
    );

    sat_counter #(.WIDTH(16)) u_ce_cnt (
        .clk_i   (gt0_rxusrclk2_in),
        .rst_i   (soft_reset_rx_in),
        .inc_i   (ce_inc),
        .count_o (code_err_count_out)
    );

    assign locked_out        = locked_q;
    assign payload_data_out  = data_q;
    assign payload_valid_out = valid_q;
    assign payload_sof_out   = sof_q;
    assign payload_eof_out   = eof_q;
    assign seq_out           = seq_q;
    assign frame_ok_out      = ok_q;
    assign frame_err_out     = err_q;
    assign seq_gap_out       = gap_q;

endmodule

// File: tb/tb_telem_rx_deframer.sv
// Scoreboard bench for telem_rx_deframer: directed frames, monitor pops expected payload/events.
module tb_telem_rx_deframer;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
        logic [23:0] seq;
    } pl_t;

    typedef struct {
        logic ok;
        logic err;
        logic gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        locked, p_valid, p_sof, p_eof, f_ok, f_err, s_gap;
    logic [31:0] p_data;
    logic [23:0] seq;
    logic [15:0] ok_cnt, err_cnt, ce_cnt;

    int errors = 0;
    int checks = 0;
    pl_t pl_q[$];
    ev_t ev_q[$];

    logic [31:0] pay [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

    telem_rx_deframer_if rx ();

    telem_rx_deframer #(
        .PAYLOAD_WORDS (4),
        .LOCK_IDLES    (16)
    ) dut (
        .gt0_rxusrclk2_in    (clk),
        .soft_reset_rx_in    (rst),
        .gt_rx               (rx),
        .locked_out          (locked),
        .payload_data_out    (p_data),
        .payload_valid_out   (p_valid),
        .payload_sof_out     (p_sof),
        .payload_eof_out     (p_eof),
        .seq_out             (seq),
        .frame_ok_out        (f_ok),
        .frame_err_out       (f_err),
        .seq_gap_out         (s_gap),
        .frame_ok_count_out  (ok_cnt),
        .frame_err_count_out (err_cnt),
        .code_err_count_out  (ce_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one word for a full cycle; returns at the following negedge.
    task automatic send(input logic [31:0] d, input logic [3:0] k,
                        input logic [3:0] dperr = 4'h0);
        rx.gt0_rxdata_in    = d;
        rx.gt0_rxcharisk_in = k;
        rx.gt0_rxdisperr_in = dperr;
        @(negedge clk);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) send(32'h505050BC, 4'b0001);
    endtask

    task automatic push_ev(input logic ok, input logic err, input logic gap);
        ev_t e;
        e.ok = ok; e.err = err; e.gap = gap;
        ev_q.push_back(e);
    endtask

    task automatic push_pl(input int idx, input logic [23:0] s);
        pl_t p;
        p.data = pay[idx]; p.sof = (idx == 0); p.eof = (idx == 3); p.seq = s;
        pl_q.push_back(p);
    endtask

    // Complete frame with the fixed payload; its byte sum is 0x88.
    task automatic frame(input logic [23:0] s, input logic [7:0] csum, input logic gap);
        if (gap) push_ev(1'b0, 1'b0, 1'b1);
        send({s, 8'hFB}, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            push_pl(i, s);
            send(pay[i], 4'b0000);
        end
        push_ev(csum == 8'h88, csum != 8'h88, 1'b0);
        send({16'h0, csum, 8'hFD}, 4'b0001);
    endtask

    // Monitor: compare every presented payload word and every pulse against the queues.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (p_valid) begin
                if (pl_q.size() == 0) begin
                    check("unexpected_payload", {32'h0, p_data}, 64'h0);
                end else begin
                    pl_t p;
                    p = pl_q.pop_front();
                    check("payload_data", {32'h0, p_data}, {32'h0, p.data});
                    check("payload_sof_eof", {62'h0, p_sof, p_eof}, {62'h0, p.sof, p.eof});
                    check("payload_seq", {40'h0, seq}, {40'h0, p.seq});
                end
            end
            if (f_ok || f_err || s_gap) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_pulse", {61'h0, f_ok, f_err, s_gap}, 64'h0);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("frame_pulses", {61'h0, f_ok, f_err, s_gap},
                          {61'h0, e.ok, e.err, e.gap});
                end
            end
        end
    end

    initial begin
        rx.gt0_rx_fsm_reset_done_in = 1'b1;
        rx.gt0_rxbyteisaligned_in   = 1'b1;
        rx.gt0_rxnotintable_in      = 4'h0;
        rx.gt0_rxdisperr_in         = 4'h0;
        rx.gt0_rxdata_in            = 32'h505050BC;
        rx.gt0_rxcharisk_in         = 4'b0001;
        repeat (3) @(negedge clk);
        check("reset_outputs", {locked, p_valid, f_ok, f_err, s_gap, seq, ok_cnt},
              64'h0);
        check("reset_counters", {32'h0, err_cnt, ce_cnt}, 64'h0);
        rst = 1'b0;

        // Lock acquisition: 15 idles processed -> unlocked; 16th -> locked.
        idles(16);
        check("locked_after_15", {63'h0, locked}, 64'h0);
        idles(1);
        check("locked_after_16", {63'h0, locked}, 64'h1);

        // Good frame, then bad checksum frame.
        frame(24'h000001, 8'h88, 1'b0);
        idles(2);
        check("ok_count_1", {48'h0, ok_cnt}, 64'h1);
        frame(24'h000002, 8'h89, 1'b0);
        idles(2);
        check("err_count_1", {48'h0, err_cnt}, 64'h1);
        check("ok_count_held", {48'h0, ok_cnt}, 64'h1);

        // Disparity error on payload word 2 aborts the frame and drops lock.
        send({24'h000003, 8'hFB}, 4'b0001);
        push_pl(0, 24'h000003);
        send(pay[0], 4'b0000);
        push_ev(1'b0, 1'b1, 1'b0);
        send(pay[1], 4'b0000, 4'b0100);
        idles(1);
        check("ce_count_1", {48'h0, ce_cnt}, 64'h1);
        check("unlocked_on_ce", {63'h0, locked}, 64'h0);
        check("err_count_2", {48'h0, err_cnt}, 64'h2);
        idles(15);
        check("relock_after_15", {63'h0, locked}, 64'h0);
        idles(1);
        check("relock_after_16", {63'h0, locked}, 64'h1);

        // First SOF after lock never flags a gap; 5 -> 7 does.
        frame(24'h000005, 8'h88, 1'b0);
        idles(1);
        frame(24'h000007, 8'h88, 1'b1);
        idles(2);
        check("ok_count_3", {48'h0, ok_cnt}, 64'h3);

        // K-word inside payload aborts; seq 8 follows 7 so no gap.
        send({24'h000008, 8'hFB}, 4'b0001);
        push_pl(0, 24'h000008);
        send(pay[0], 4'b0000);
        push_ev(1'b0, 1'b1, 1'b0);
        idles(3);
        check("err_count_3", {48'h0, err_cnt}, 64'h3);
        check("locked_after_abort", {63'h0, locked}, 64'h1);

        // Soft reset mid-payload clears everything at once.
        send({24'h000009, 8'hFB}, 4'b0001);
        push_pl(0, 24'h000009);
        send(pay[0], 4'b0000);
        push_pl(1, 24'h000009);
        send(pay[1], 4'b0000);
        send(pay[2], 4'b0000);
        rst = 1'b1;
        #1;
        check("soft_reset_outputs", {locked, p_valid, p_sof, p_eof, f_ok, f_err, s_gap, seq},
              64'h0);
        check("soft_reset_counters", {16'h0, ok_cnt, err_cnt, ce_cnt}, 64'h0);
        repeat (3) @(negedge clk);
        check("reset_still_unlocked", {62'h0, locked, p_valid}, 64'h0);

        check("payload_queue_drained", 64'(pl_q.size()), 64'h0);
        check("event_queue_drained", 64'(ev_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
